seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Sequential unsigned restoring divider: the inverse operation to the
//   multiplier datapath. Computes quotient and remainder one bit per clock
//   using a shift/subtract loop. Accepts operands with a start pulse and
//   signals completion with a single-cycle done pulse. Sits beside the
//   multiplier as the arithmetic unit's divide path.
// PARAMETERS
//   WIDTH  8  operand, quotient and remainder width in bits (>= 2)
// PORTS
//   clk          in   1      single clock; all state changes on rising edge
//   rst_n        in   1      reset, asynchronous, active-low
//   start        in   1      request; sampled only in IDLE
//   dividend     in   WIDTH  unsigned dividend, captured when start accepted
//   divisor      in   WIDTH  unsigned divisor, captured when start accepted
//   busy         out  1      high while in RUN
//   done         out  1      one-cycle pulse; results valid from this cycle
//   quotient     out  WIDTH  registered quotient
//   remainder    out  WIDTH  registered remainder
//   div_by_zero  out  1      registered flag, set when captured divisor == 0
// BEHAVIOUR
//   - Reset (rst_n low, any time, incl. mid-division): state IDLE; busy,
//     done, div_by_zero = 0; quotient, remainder = 0; internal regs cleared.
//   - States: IDLE, RUN, DONE.
//     IDLE: start=1 at edge k -> capture operands, iteration count = 0;
//       divisor != 0 -> RUN; divisor == 0 -> DONE directly.
//     RUN: one iteration per edge; after WIDTH iterations (edge k+WIDTH) ->
//       DONE, quotient/remainder outputs written on that same edge.
//     DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
//   - Latency: divisor != 0 -> done high in the cycle after edge k+WIDTH
//     (WIDTH+1 edges after start sampled); divisor == 0 -> done high after
//     edge k (1 edge).
//   - busy = 1 exactly while state == RUN; done and busy never both high.
//   - start ignored in RUN and DONE (no queuing, operands not re-captured);
//     start high in the IDLE cycle after DONE is accepted normally.
//   - Iteration (restoring): partial remainder P is WIDTH+1 bits.
//     P' = {P[WIDTH-1:0], next dividend MSB}; if P' >= divisor then
//     P = P' - divisor, quotient bit = 1; else P = P', bit = 0. Dividend
//     bits consumed MSB first; quotient bits shifted in LSB side.
//   - Result: quotient = floor(dividend/divisor), remainder = dividend mod
//     divisor; remainder < divisor always; no overflow possible.
//   - Divide by zero: quotient = all ones, remainder = dividend,
//     div_by_zero = 1; still reported via done.
//   - quotient, remainder, div_by_zero hold last result until written by the
//     next completed division; div_by_zero cleared on next non-zero result.
//   - Input changes after capture have no effect on the running division.
// TESTING
//   1 WIDTH=8, 100/7 -> done 9 edges after start; q=14, r=2, dbz=0.
//   2 255/1 -> q=255, r=0; 5/9 -> q=0, r=5; 0/3 -> q=0, r=0.
//   3 200/0 -> done after 1 edge, busy never high; q=8'hFF, r=200, dbz=1;
//     then 9/3 -> q=3, r=0, dbz=0.
//   4 start 100/7, toggle start and change operands for 4 cycles of RUN ->
//     ignored; result q=14, r=2; then start in the IDLE cycle right after
//     done -> accepted, next result correct.
//   5 start 250/3, drop rst_n at RUN iteration 4 -> all outputs 0
//     immediately, no done; after release 250/3 -> q=83, r=1.
//   6 Random sweep 2000 pairs incl. divisor 0/1/255 vs reference model ->
//     q, r, dbz match; done one cycle; busy/done never overlap.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero short-circuits straight to DONE with quotient all ones.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    count_reg;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;
  logic             q_bit;

  // The stored remainder is always below the divisor, so WIDTH bits suffice;
  // the shifted value needs the extra bit for the compare.
  always_comb begin
    p_shift = {p_reg, dvd_reg[WIDTH-1]};
    p_next  = p_shift[WIDTH-1:0];
    q_bit   = 1'b0;
    if (p_shift >= {1'b0, dvs_reg}) begin
      p_next = WIDTH'(p_shift - {1'b0, dvs_reg});
      q_bit  = 1'b1;
    end
    q_next = {q_reg[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      count_reg   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_reg   <= dividend;
            dvs_reg   <= divisor;
            p_reg     <= '0;
            q_reg     <= '0;
            count_reg <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_reg   <= DONE;
            end else begin
              busy      <= 1'b1;
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          p_reg     <= p_next;
          q_reg     <= q_next;
          dvd_reg   <= dvd_reg << 1;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            quotient    <= q_next;
            remainder   <= p_next;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider results, latency, busy/done behaviour and reset.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  // Called #1 after an edge with the DUT in IDLE; returns #1 after the edge
  // following done, with the DUT back in IDLE.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_q, input logic [7:0] exp_r,
                        input bit meddle, input bit verbose);
    int  edges;
    bit  seen_busy;
    bit  overlap;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start     = 1'b0;
    edges     = 1;
    seen_busy = 1'b0;
    overlap   = 1'b0;
    while (!done && edges < 40) begin
      if (busy) seen_busy = 1'b1;
      if (meddle && edges <= 4) begin
        start    = ~start;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    if (busy && done) overlap = 1'b1;
    check_val("latency", edges, (b == 0) ? 1 : 9);
    check_val("quotient", quotient, exp_q);
    check_val("remainder", remainder, exp_r);
    check_val("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
    check_val("busy_done_overlap", overlap, 0);
    if (b == 0) check_val("busy_on_dbz", seen_busy, 0);
    @(posedge clk); #1;
    check_val("done_one_cycle", done, 0);
    if (verbose)
      $display("div %0d/%0d -> q=%0d r=%0d dbz=%0d edges=%0d",
               a, b, quotient, remainder, div_by_zero, edges);
  endtask

  initial begin
    bit saw_done;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_q", quotient, 0);
    check_val("reset_r", remainder, 0);
    check_val("reset_dbz", div_by_zero, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1);
    do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1);
    do_div(8'd5,   8'd9, 8'd0,   8'd5, 1'b0, 1'b1);
    do_div(8'd0,   8'd3, 8'd0,   8'd0, 1'b0, 1'b1);
    do_div(8'd200, 8'd0, 8'hFF,  8'd200, 1'b0, 1'b1);
    do_div(8'd9,   8'd3, 8'd3,   8'd0, 1'b0, 1'b1);

    // Interference during RUN, then an immediate restart in the first IDLE cycle.
    do_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b1, 1'b1);
    do_div(8'd77,  8'd5, 8'd15, 8'd2, 1'b0, 1'b1);

    // Reset in the middle of a division.
    start    = 1'b1;
    dividend = 8'd250;
    divisor  = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("midreset_busy", busy, 0);
    check_val("midreset_done", done, 0);
    check_val("midreset_q", quotient, 0);
    check_val("midreset_r", remainder, 0);
    check_val("midreset_dbz", div_by_zero, 0);
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_val("midreset_no_done", saw_done, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-division applied and released");
    do_div(8'd250, 8'd3, 8'd83, 8'd1, 1'b0, 1'b1);

    // Random sweep with forced corner divisors.
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 8'd0;
        1:       b = 8'd1;
        2:       b = 8'd255;
        default: b = 8'($urandom);
      endcase
      if (b == 0) do_div(a, b, 8'hFF, a, 1'b0, 1'b0);
      else        do_div(a, b, a / b, a % b, 1'b0, 1'b0);
    end
    $display("random sweep of 2000 divisions complete");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
